// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction-word stream from the program source into the loader.
//   in_valid  : in_data / in_last are valid this cycle
//   in_data   : instruction word, INSTR_W bits
//   in_last   : marks the final word of the program
//   in_ready  : loader accepts a word this cycle (a beat moves when valid & ready)
// Modports: master = program source, slave = loader.
interface imem_loader_if #(
    parameter int unsigned INSTR_W = 16
);
    logic               in_valid;
    logic [INSTR_W-1:0] in_data;
    logic               in_last;
    logic               in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: run-time program loader for the 16-bit MiniMIPS instruction memory.
// Accepts instruction words over a valid/ready stream and writes them to
// consecutive word addresses starting at 0, holding the CPU until the whole
// program is resident.
//
// Ports:
//   clk, reset    : clock (posedge) and synchronous active-high reset
//   start         : one-cycle pulse; begins a load from IDLE, DONE or ERR
//   stream        : imem_loader_if.slave (in_valid, in_data, in_last, in_ready)
//   mem_we/addr/wdata : instruction memory write port (addr/wdata hold when idle)
//   cpu_hold      : 1 = processor held at PC 0
//   done          : program fully written
//   err           : overflow (DEPTH words without in_last) or checksum mismatch
//   count         : words written by the current / most recent load
//
// Optional feature, macro IMEM_LOADER_CHECKSUM_EN:
//   adds input expected_sum (sampled with the in_last beat) and output checksum
//   (running XOR of accepted words); a mismatch at the end of the load goes to ERR.
module imem_loader #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    imem_loader_if.slave       stream,
`ifdef IMEM_LOADER_CHECKSUM_EN
    input  logic [INSTR_W-1:0] expected_sum,
    output logic [INSTR_W-1:0] checksum,
`endif
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [ADDR_W:0]    count
);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, FINISH, DONE, ERR} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]  ptr, ptr_nx;
    logic               in_ready_q, in_ready_nx;
    logic               mem_we_nx;
    logic [ADDR_W-1:0]  mem_addr_nx;
    logic [INSTR_W-1:0] mem_wdata_nx;
    logic               cpu_hold_nx, done_nx, err_nx;
    logic [ADDR_W:0]    count_nx;
    logic               accept, restart, sum_ok;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] sum_q, sum_nx, exp_q, exp_nx;
    assign checksum = sum_q;
    assign sum_ok   = (sum_q == exp_q);
`else
    assign sum_ok   = 1'b1;
`endif

    assign stream.in_ready = in_ready_q;
    assign accept  = in_ready_q && stream.in_valid;
    assign restart = start && (state == IDLE || state == DONE || state == ERR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD: begin
                if (accept) begin
                    if (stream.in_last)   state_nx = FINISH;
                    else if (ptr == '1)   state_nx = ERR;
                end
            end
            FINISH:  state_nx = sum_ok ? DONE : ERR;
            DONE:    if (start) state_nx = LOAD;
            ERR:     if (start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and datapath.
    // Status flags are derived from state_nx so they change in the same cycle
    // the state does, keeping every output registered.
    always_comb begin
        ptr_nx       = ptr;
        mem_we_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        count_nx     = count;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_nx       = sum_q;
        exp_nx       = exp_q;
`endif
        if (restart) begin
            ptr_nx   = '0;
            count_nx = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_nx   = '0;
`endif
        end
        if (accept) begin
            mem_we_nx    = 1'b1;
            mem_addr_nx  = ptr;
            mem_wdata_nx = stream.in_data;
            ptr_nx       = ptr + 1'b1;
            if (count != COUNT_MAX) count_nx = count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_nx = sum_q ^ stream.in_data;
            if (stream.in_last) exp_nx = expected_sum;
`endif
        end
        in_ready_nx = (state_nx == LOAD);
        cpu_hold_nx = (state_nx != DONE);
        done_nx     = (state_nx == DONE);
        err_nx      = (state_nx == ERR);
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            in_ready_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            exp_q      <= '0;
`endif
        end else begin
            ptr        <= ptr_nx;
            in_ready_q <= in_ready_nx;
            mem_we     <= mem_we_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            cpu_hold   <= cpu_hold_nx;
            done       <= done_nx;
            err        <= err_nx;
            count      <= count_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_nx;
            exp_q      <= exp_nx;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios plus randomized traffic for imem_loader,
// checked every cycle against a behavioural model of the loader.
// Built with ADDR_W = 2 so the DEPTH boundary is exercised constantly.
// Optional macro IMEM_LOADER_CHECKSUM_EN enables the checksum scenarios.
module tb_imem_loader;
    localparam int unsigned IW    = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic          cpu_hold, done, err;
    logic [AW:0]   count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [IW-1:0] expected_sum = '0;
    logic [IW-1:0] checksum;
`endif

    imem_loader_if #(.INSTR_W(IW)) bus ();

    imem_loader #(.INSTR_W(IW), .ADDR_W(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stream(bus),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .expected_sum(expected_sum),
        .checksum(checksum),
`endif
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err),
        .count(count)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // loading: words are being accepted; fin_pending: the last word was just
    // written and the verdict (done or err) lands one cycle later.
    bit          m_loading = 0, m_fin = 0;
    bit          m_we = 0, m_hold = 1, m_done = 0, m_err = 0;
    int unsigned m_addr = 0, m_wdata = 0, m_count = 0, m_next = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    int unsigned m_sum = 0, m_exp = 0;
`endif

    always @(posedge clk) begin
        if (reset) begin
            m_loading = 0; m_fin = 0; m_we = 0; m_hold = 1; m_done = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_count = 0; m_next = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            m_sum = 0;
`endif
        end else begin
            m_we = 0;
            if (m_fin) begin
                m_fin = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (m_sum != m_exp) m_err = 1; else m_done = 1;
`else
                m_done = 1;
`endif
                m_hold = !m_done;
            end else if (m_loading) begin
                if (bus.in_valid) begin
                    m_we    = 1;
                    m_addr  = m_next;
                    m_wdata = bus.in_data;
                    if (m_count < DEPTH) m_count++;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    m_sum = m_sum ^ bus.in_data;
                    if (bus.in_last) m_exp = expected_sum;
`endif
                    if (bus.in_last) begin
                        m_loading = 0; m_fin = 1;
                    end else if (m_next == DEPTH - 1) begin
                        m_loading = 0; m_err = 1;
                    end
                    m_next = (m_next + 1) % DEPTH;
                end
            end else if (start) begin
                m_loading = 1; m_next = 0; m_count = 0;
                m_done = 0; m_err = 0; m_hold = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                m_sum = 0;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  bus.in_ready, m_loading);
            chk("mem_we",    mem_we,       m_we);
            chk("mem_addr",  mem_addr,     m_addr);
            chk("mem_wdata", mem_wdata,    m_wdata);
            chk("cpu_hold",  cpu_hold,     m_hold);
            chk("done",      done,         m_done);
            chk("err",       err,          m_err);
            chk("count",     count,        m_count);
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk("checksum",  checksum,     m_sum);
`endif
        end
    end

    // ---------------- write log for literal checks ----------------
    typedef struct { int unsigned cyc; int unsigned addr; int unsigned data; } wr_t;
    wr_t         wlog[$];
    int unsigned cyc = 0;
    logic [IW-1:0] exp_d[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (mem_we === 1'b1) wlog.push_back('{cyc, mem_addr, mem_wdata});

    task automatic check_log(input string tag, input bit consec);
        chk({tag, "_nwrites"}, wlog.size(), exp_d.size());
        for (int i = 0; i < wlog.size() && i < exp_d.size(); i++) begin
            chk({tag, "_addr"}, wlog[i].addr, i);
            chk({tag, "_data"}, wlog[i].data, exp_d[i]);
            if (consec && i > 0) chk({tag, "_gap"}, wlog[i].cyc - wlog[i-1].cyc, 1);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", bus.in_ready, 1);
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_mem_we"},   mem_we,       0);
        chk({tag, "_mem_addr"}, mem_addr,     0);
        chk({tag, "_wdata"},    mem_wdata,    0);
        chk({tag, "_hold"},     cpu_hold,     1);
        chk({tag, "_done"},     done,         0);
        chk({tag, "_err"},      err,          0);
        chk({tag, "_count"},    count,        0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // Reset held for two cycles
        reset = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;

        // Normal back-to-back load, last word at DEPTH-1
        wlog.delete();
        exp_d = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        pulse_start();
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        send(16'h9ABC, 1'b0);
        send(16'hDEF0, 1'b1);
        bus.in_valid = 1'b0;
        chk("normal_done_n1", done, 0);
        chk("normal_ready_n1", bus.in_ready, 0);
        tick();
        chk("normal_done", done, 1);
        chk("normal_hold", cpu_hold, 0);
        chk("normal_count", count, 4);
        check_log("normal", 1'b1);

        // Gapped input
        wlog.delete();
        exp_d = '{16'h00A1, 16'h00B2, 16'h00C3};
        pulse_start();
        send(16'h00A1, 1'b0); idle(2);
        send(16'h00B2, 1'b0); idle(2);
        send(16'h00C3, 1'b1); idle(2);
        chk("gap_done", done, 1);
        chk("gap_count", count, 3);
        check_log("gap", 1'b0);

        // Overflow: DEPTH words without in_last
        wlog.delete();
        exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        pulse_start();
        foreach (exp_d[i]) send(exp_d[i], 1'b0);
        bus.in_valid = 1'b0;
        tick();
        chk("ovf_err", err, 1);
        chk("ovf_hold", cpu_hold, 1);
        chk("ovf_count", count, 4);
        chk("ovf_done", done, 0);
        check_log("ovf", 1'b1);
        pulse_start();
        chk("ovf_restart_err", err, 0);
        chk("ovf_restart_count", count, 0);
        send(16'h5555, 1'b1);
        idle(2);
        chk("ovf_reload_done", done, 1);
        chk("ovf_reload_count", count, 1);

        // Reload from DONE, then abort with reset
        pulse_start();
        chk("reload_hold", cpu_hold, 1);
        chk("reload_done", done, 0);
        chk("reload_count", count, 0);
        wlog.delete();
        exp_d = '{16'hAAAA, 16'hBBBB};
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b1);
        idle(2);
        chk("reload_done2", done, 1);
        check_log("reload", 1'b1);
        pulse_start();
        send(16'hCCCC, 1'b0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk_reset_vals("abort");
        reset = 1'b0;
        tick();
        chk("abort_idle_ready", bus.in_ready, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        expected_sum = 16'h0FF0;
        pulse_start();
        send(16'h00FF, 1'b0);
        send(16'h0F0F, 1'b1);
        idle(2);
        chk("csum_ok_done", done, 1);
        chk("csum_ok_err", err, 0);
        chk("csum_value", checksum, 16'h0FF0);
        expected_sum = 16'h0000;
        pulse_start();
        send(16'h00FF, 1'b0);
        send(16'h0F0F, 1'b1);
        idle(2);
        chk("csum_bad_err", err, 1);
        chk("csum_bad_hold", cpu_hold, 1);
        chk("csum_bad_done", done, 0);
`endif

        // Randomized traffic, checked by the per-cycle model comparison
        repeat (3000) begin
            start        = ($urandom_range(9) == 0);
            reset        = ($urandom_range(299) == 0);
            bus.in_valid = $urandom_range(1);
            bus.in_data  = IW'($urandom);
            bus.in_last  = ($urandom_range(3) == 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
            expected_sum = $urandom_range(1) ? IW'(m_sum ^ bus.in_data) : IW'($urandom);
`endif
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream program-load stage for the 16-bit-instruction MiniMIPS core.
- Accepts a stream of instruction words over a valid/ready handshake and writes them sequentially into instruction memory starting at word address 0.
- Holds the processor (cpu_hold) until the whole program is resident.
- Replaces file-based preloading of instruction memory so a program can be loaded at run time.

Parameters:
- INSTR_W, 16, instruction word width (matches the core's instruction width).
- ADDR_W, 8, instruction memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load.
- in_valid  input  1  in_data is valid.
- in_data  input  INSTR_W  instruction word.
- in_last  input  1  qualifies the final word of the program.
- in_ready  output  1  loader can accept a word this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  ADDR_W  instruction memory word address.
- mem_wdata  output  INSTR_W  instruction memory write data.
- cpu_hold  output  1  1 = processor PC held at 0 and must not fetch.
- done  output  1  program fully written.
- err  output  1  overflow: DEPTH words accepted without in_last.
- count  output  ADDR_W+1  number of words written in the current or most recent load.

Behaviour:
- Reset (synchronous, active-high) and its values:
  - State = IDLE.
  - in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_hold = 1, done = 0, err = 0, count = 0.
  - Reset asserted mid-load aborts the load immediately. Memory contents already written are left as they are.
- States: IDLE, LOAD, FINISH, DONE, ERR. All outputs are registered.
- IDLE:
  - in_ready = 0, cpu_hold = 1.
  - start moves to LOAD; the internal write pointer and count clear to 0.
- LOAD:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready.
  - Accepted in cycle N → in cycle N+1: mem_we = 1, mem_addr = pointer, mem_wdata = in_data. The pointer and count increment.
  - No accepted beat → mem_we = 0 the next cycle.
  - in_valid may stay high continuously; one word is accepted per cycle with no bubbles.
  - Accepted beat with in_last = 1 → FINISH. in_ready drops to 0 in the same cycle the write is issued.
  - Accepted beat at pointer DEPTH-1 with in_last = 0 → the word is written, then state goes to ERR.
  - A beat at DEPTH-1 with in_last = 1 is legal and goes to FINISH.
  - start is ignored while in LOAD.
- FINISH: one cycle carrying the final mem_we; then DONE.
- DONE:
  - done = 1, cpu_hold = 0, in_ready = 0, mem_we = 0.
  - Timing: last word accepted in cycle N → done = 1 and cpu_hold = 0 in cycle N+2.
  - start in DONE → LOAD. In the following cycle done = 0 and cpu_hold = 1; count clears.
- ERR:
  - err = 1, cpu_hold = 1, done = 0, in_ready = 0.
  - Remains in ERR until start (→ LOAD, err clears) or reset.
- count saturates at DEPTH and holds its value in DONE and ERR.
- mem_addr and mem_wdata hold their last values when mem_we = 0.
- Minimum program length is 1 word; there is no zero-length load.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Extra input expected_sum [INSTR_W-1:0], sampled when the in_last beat is accepted.
  - Extra output checksum [INSTR_W-1:0]: running XOR of all accepted words. It clears on start and on reset.
  - In FINISH, checksum is compared against expected_sum. Match → DONE. Mismatch → ERR (err = 1, cpu_hold stays 1).
- When undefined: no extra ports; FINISH always goes to DONE.

Test Plan:
- Reset: assert reset 2 cycles → every output at its reset value; cpu_hold = 1.
- Normal load: start, then 4 back-to-back words 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 (last flagged) →
  - mem_we high 4 consecutive cycles at addresses 0..3 with the same data.
  - done = 1 and cpu_hold = 0 exactly 2 cycles after the 4th accept; count = 4.
- Gapped input: 3 words with in_valid low for 2 cycles between each → exactly 3 writes at addresses 0, 1, 2; no spurious mem_we; count = 3.
- Overflow with ADDR_W = 2: start, 4 words with in_last = 0 → addresses 0..3 written, then err = 1, cpu_hold = 1, count = 4. A subsequent start clears err; a 1-word load then reaches DONE.
- Reload and abort:
  - In DONE, pulse start → cpu_hold = 1 next cycle; a 2-word reload overwrites addresses 0..1.
  - Assert reset after the 1st reload word → outputs return to reset values, state IDLE.
- Checksum (macro defined): words 16'h00FF, 16'h0F0F with expected_sum 16'h0FF0 → DONE. The same words with expected_sum 16'h0000 → err = 1.
